// File: rtl/agc_gain_scheduler.sv
// Closed-loop AGC gain scheduler: block-averages envelope samples, applies gain += alpha*(ref-mean), publishes saturated gain.
// Latency: the new gain and its gain_valid pulse appear 3 cycles after the cycle presenting the last sample of a block.
// Backpressure: none on env (samples outside ACCUM are dropped); config uses valid/ready, ready only in IDLE and UPDATE.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   en                          loop enable; dropping it mid-block discards the partial block
//   cfg_valid/cfg_ready         config handshake carrying cfg_alpha (UQ F_ALPHA) and cfg_reference
//   env_data/env_valid          per-sample envelope magnitude
//   gain/gain_valid             current gain (UQ F_GAIN) and one-cycle update pulse
//   locked                      error has stayed within LOCK_TOL for LOCK_CNT consecutive blocks
//   busy                        block accumulation in progress
module agc_gain_scheduler #(
    parameter int W_IN     = 16,
    parameter int W_ALPHA  = 16,
    parameter int F_ALPHA  = 14,
    parameter int W_GAIN   = 16,
    parameter int F_GAIN   = 14,
    parameter int LOG2_BLK = 6,
    parameter int LOCK_TOL = 64,
    parameter int LOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [W_ALPHA-1:0] cfg_alpha,
    input  logic [W_IN-1:0]    cfg_reference,
    input  logic [W_IN-1:0]    env_data,
    input  logic               env_valid,
    output logic [W_GAIN-1:0]  gain,
    output logic               gain_valid,
    output logic               locked,
    output logic               busy
);

    localparam int W_ACC  = W_IN + LOG2_BLK;
    localparam int W_CNT  = LOG2_BLK + 1;
    localparam int W_ERR  = W_IN + 1;
    localparam int W_PROD = W_ALPHA + 1 + W_ERR;
    // Sum must hold the unsigned gain plus a signed step with headroom to detect both rails.
    localparam int W_SUM  = ((W_PROD > W_GAIN) ? W_PROD : W_GAIN) + 2;
    localparam int W_LCK  = $clog2(LOCK_CNT + 1);
    localparam int BLK    = 1 << LOG2_BLK;

    localparam logic [W_GAIN-1:0] GAIN_ONE = W_GAIN'(1 << F_GAIN);
    localparam logic [W_GAIN-1:0] GAIN_MAX = {W_GAIN{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ERR    = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [W_ACC-1:0]          acc_q, acc_d;
    logic [W_CNT-1:0]          cnt_q, cnt_d;
    logic signed [W_ERR-1:0]   err_q, err_d;
    logic [W_ALPHA-1:0]        alpha_q, alpha_d;
    logic [W_IN-1:0]           ref_q, ref_d;
    logic [W_GAIN-1:0]         gain_q, gain_d;
    logic                      gain_vld_q, gain_vld_d;
    logic                      locked_q, locked_d;
    logic [W_LCK-1:0]          lock_cnt_q, lock_cnt_d;

    logic [W_IN-1:0]           mean;
    logic signed [W_ERR-1:0]   err_calc;
    logic [W_ERR-1:0]          err_abs;
    logic                      in_tol;
    logic signed [W_PROD-1:0]  prod;
    logic signed [W_PROD-1:0]  step;
    logic signed [W_SUM-1:0]   sum;
    logic [W_GAIN-1:0]         gain_sat;
    logic                      cfg_fire;

    assign cfg_ready  = (state_q == IDLE) || (state_q == UPDATE);
    assign busy       = (state_q == ACCUM);
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign gain       = gain_q;
    assign gain_valid = gain_vld_q;
    assign locked     = locked_q;

    // Block mean is a plain truncating shift since the block length is a power of two.
    assign mean     = acc_q[W_ACC-1:LOG2_BLK];
    assign err_calc = $signed({1'b0, ref_q}) - $signed({1'b0, mean});

    assign err_abs = err_q[W_ERR-1] ? W_ERR'(-err_q) : W_ERR'(err_q);
    assign in_tol  = (err_abs <= W_ERR'(LOCK_TOL));

    // Arithmetic shift floors toward -inf, so small negative errors still nudge the gain down.
    assign prod = $signed({1'b0, alpha_q}) * err_q;
    assign step = prod >>> F_ALPHA;
    assign sum  = $signed({{(W_SUM - W_GAIN){1'b0}}, gain_q})
                + $signed({{(W_SUM - W_PROD){step[W_PROD-1]}}, step});

    always_comb begin
        gain_sat = sum[W_GAIN-1:0];
        if (sum[W_SUM-1]) begin
            gain_sat = '0;
        end else if (|sum[W_SUM-2:W_GAIN]) begin
            gain_sat = GAIN_MAX;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        alpha_d    = alpha_q;
        ref_d      = ref_q;
        gain_d     = gain_q;
        gain_vld_d = 1'b0;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (!en) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (env_valid) begin
                    acc_d = acc_q + W_ACC'(env_data);
                    cnt_d = cnt_q + W_CNT'(1);
                    if (cnt_q == W_CNT'(BLK - 1)) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                err_d   = err_calc;
                state_d = UPDATE;
            end
            UPDATE: begin
                gain_d     = gain_sat;
                gain_vld_d = 1'b1;
                if (in_tol) begin
                    if (lock_cnt_q != W_LCK'(LOCK_CNT)) begin
                        lock_cnt_d = lock_cnt_q + W_LCK'(1);
                    end
                end else begin
                    lock_cnt_d = '0;
                end
                locked_d = (lock_cnt_d == W_LCK'(LOCK_CNT));
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = en ? ACCUM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New config restarts lock qualification; it overrides a lock reached in the same UPDATE.
        // The UPDATE above already consumed the old alpha/reference, so new values only affect the next block.
        if (cfg_fire) begin
            alpha_d    = cfg_alpha;
            ref_d      = cfg_reference;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            alpha_q    <= '0;
            ref_q      <= '0;
            gain_q     <= GAIN_ONE;
            gain_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            alpha_q    <= alpha_d;
            ref_q      <= ref_d;
            gain_q     <= gain_d;
            gain_vld_q <= gain_vld_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: tb/tb_agc_gain_scheduler.sv
// Testbench for agc_gain_scheduler: directed blocks with hand-computed gains, scoreboard-checked on gain_valid.
// Latency: expected pulses are tagged with the cycle they must appear in (last sample cycle + 3).
// Backpressure: config offered only in IDLE/UPDATE slots; cfg_ready is checked where it matters.
module tb_agc_gain_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_alpha;
    logic [15:0] cfg_reference;
    logic [15:0] env_data;
    logic        env_valid;
    logic [15:0] gain;
    logic        gain_valid;
    logic        locked;
    logic        busy;

    agc_gain_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_alpha     (cfg_alpha),
        .cfg_reference (cfg_reference),
        .env_data      (env_data),
        .env_valid     (env_valid),
        .gain          (gain),
        .gain_valid    (gain_valid),
        .locked        (locked),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] g;
        logic        l;
        int          c;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every gain_valid pulse must match the oldest expected update.
    always @(negedge clk) begin : mon
        exp_t e;
        if (gain_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gain_valid: got pulse with gain=%0d at cycle %0d, expected no pulse", gain, cyc);
            end else begin
                e = sb.pop_front();
                chk("gain", {16'd0, gain}, {16'd0, e.g});
                chk("locked", {31'd0, locked}, {31'd0, e.l});
                chk("pulse_cycle", cyc, e.c);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_gain"}, {16'd0, gain}, 32'd16384);
        chk({tag, "_gain_valid"}, {31'd0, gain_valid}, 32'd0);
        chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    endtask

    task automatic cfg_idle(input logic [15:0] a, input logic [15:0] r);
        cfg_alpha     = a;
        cfg_reference = r;
        cfg_valid     = 1'b1;
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        tick;
        cfg_valid = 1'b0;
    endtask

    task automatic start;
        en = 1'b1;
        tick;
        chk("busy_accum", {31'd0, busy}, 32'd1);
    endtask

    // One 64-sample block from ACCUM. mode 1: offer config in the UPDATE cycle; mode 2: reset in UPDATE.
    // Samples of 0xFFFF are presented during ERR/UPDATE and must be dropped.
    task automatic run_block(input logic [15:0] val, input bit gaps, input bit push,
                             input logic [15:0] eg, input bit el, input int mode,
                             input logic [15:0] na, input logic [15:0] nr);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            env_data  = val;
            env_valid = 1'b1;
            if (i == 63 && push) begin
                e.g = eg;
                e.l = el;
                e.c = cyc + 3;
                sb.push_back(e);
            end
            tick;
            if (gaps && i != 63) begin
                env_valid = 1'b0;
                env_data  = 16'hFFFF;
                tick;
            end
        end
        env_valid = 1'b1;
        env_data  = 16'hFFFF;
        chk("cfg_ready_err", {31'd0, cfg_ready}, 32'd0);
        tick;
        chk("cfg_ready_update", {31'd0, cfg_ready}, 32'd1);
        if (mode == 1) begin
            cfg_alpha     = na;
            cfg_reference = nr;
            cfg_valid     = 1'b1;
        end
        if (mode == 2) begin
            reset = 1'b1;
        end
        tick;
        env_valid = 1'b0;
        cfg_valid = 1'b0;
        if (mode == 2) begin
            check_reset_state("rst_update");
            reset = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        en            = 1'b0;
        cfg_valid     = 1'b0;
        cfg_alpha     = '0;
        cfg_reference = '0;
        env_data      = '0;
        env_valid     = 1'b0;
        tick;
        tick;
        check_reset_state("rst_init");
        reset = 1'b0;
        tick;

        // Basic proportional updates: err=+4096 -> +2048, then err=-4096 -> -2048.
        cfg_idle(16'd8192, 16'd8192);
        start;
        run_block(16'd4096, 1'b0, 1'b1, 16'd18432, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd12288, 1'b0, 1'b1, 16'd16384, 1'b0, 0, 16'd0, 16'd0);
        en = 1'b0;
        tick;

        // Saturation: step +65535 clamps high; then -65535 twice reaches and clamps at 0.
        cfg_idle(16'd16384, 16'd65535);
        start;
        run_block(16'd0, 1'b0, 1'b1, 16'd65535, 1'b0, 0, 16'd0, 16'd0);
        en = 1'b0;
        tick;
        cfg_idle(16'd16384, 16'd0);
        start;
        run_block(16'd65535, 1'b0, 1'b1, 16'd0, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd65535, 1'b0, 1'b1, 16'd0, 1'b0, 0, 16'd0, 16'd0);
        en = 1'b0;
        tick;

        // Reset from gain 0 restores 1.0.
        reset = 1'b1;
        tick;
        check_reset_state("rst_idle");
        reset = 1'b0;
        tick;

        // Floor: alpha=1, err=-1 -> step=-1.
        cfg_idle(16'd1, 16'd99);
        start;
        run_block(16'd100, 1'b0, 1'b1, 16'd16383, 1'b0, 0, 16'd0, 16'd0);
        en = 1'b0;
        tick;

        // Lock: four zero-error blocks lock, err=-1000 unlocks (step -500).
        cfg_idle(16'd8192, 16'd5000);
        start;
        run_block(16'd5000, 1'b0, 1'b1, 16'd16383, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd5000, 1'b0, 1'b1, 16'd16383, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd5000, 1'b0, 1'b1, 16'd16383, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd5000, 1'b0, 1'b1, 16'd16383, 1'b1, 0, 16'd0, 16'd0);
        run_block(16'd6000, 1'b0, 1'b1, 16'd15883, 1'b0, 0, 16'd0, 16'd0);
        // err=+40 -> step +20 with alpha 0.5; the 4th would lock but a config lands in that UPDATE.
        run_block(16'd4960, 1'b0, 1'b1, 16'd15903, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd4960, 1'b0, 1'b1, 16'd15923, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd4960, 1'b0, 1'b1, 16'd15943, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd4960, 1'b0, 1'b1, 16'd15963, 1'b0, 1, 16'd16384, 16'd5000);
        // Lock counter restarts from zero under the new config.
        run_block(16'd5000, 1'b0, 1'b1, 16'd15963, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd5000, 1'b0, 1'b1, 16'd15963, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd5000, 1'b0, 1'b1, 16'd15963, 1'b0, 0, 16'd0, 16'd0);
        run_block(16'd5000, 1'b0, 1'b1, 16'd15963, 1'b1, 0, 16'd0, 16'd0);

        // Reset mid-ACCUM while locked with a non-unity gain.
        for (int i = 0; i < 20; i++) begin
            env_data  = 16'd5000;
            env_valid = 1'b1;
            tick;
        end
        env_valid = 1'b0;
        reset     = 1'b1;
        tick;
        check_reset_state("rst_accum");
        reset = 1'b0;
        en    = 1'b0;
        tick;

        // en dropped after 30 samples: partial block discarded, no pulse.
        cfg_idle(16'd16384, 16'd5000);
        start;
        for (int i = 0; i < 30; i++) begin
            env_data  = 16'd0;
            env_valid = 1'b1;
            tick;
        end
        env_valid = 1'b0;
        en        = 1'b0;
        tick;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        tick;
        tick;
        chk("abort_gain", {16'd0, gain}, 32'd16384);

        // Full block with gaps: err=+1000, alpha 1.0 -> +1000.
        start;
        run_block(16'd4000, 1'b1, 1'b1, 16'd17384, 1'b0, 0, 16'd0, 16'd0);
        // Reset during UPDATE suppresses the update.
        run_block(16'd4000, 1'b0, 1'b0, 16'd0, 1'b0, 2, 16'd0, 16'd0);
        en = 1'b0;

        for (int i = 0; i < 5; i++) tick;
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
